sevseg_capture: RTL and testbench

//  Receive-side monitor for the multiplexed seven-segment interface (SEVSEG_SEG_PINS / SEVSEG_SEL_PINS).
//  It samples the scanned segment/select pins, waits for them to be stable, and rebuilds one value per digit.
//  It decodes each pattern back to a hex nibble and reports when a full refresh frame has been seen.
//  It sits on the board side as a self-check block, or in benches, opposite the SoC's display driver.

---
 rtl/sevseg_pkg.sv | 24 ++
 rtl/sevseg_decode.sv | 21 ++
 rtl/sevseg_capture.sv | 170 +++++++++++++++++
 tb/tb_sevseg_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared types, glyph table and helpers for the seven-segment capture path.
package sevseg_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned GLYPH_N = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_e;

    // Active-high gfedcba patterns; entry i is the glyph for nibble i.
    localparam logic [GLYPH_N-1:0][SEG_W-1:0] GLYPH_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Combinational reverse lookup: active-high segment pattern to hex nibble.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern_i,
    output logic             valid_c_o,
    output logic [NIB_W-1:0] nibble_c_o
);

    always_comb begin
        valid_c_o  = 1'b0;
        nibble_c_o = '0;
        for (int i = 0; i < int'(GLYPH_N); i++) begin
            if (pattern_i == GLYPH_TBL[i]) begin
                valid_c_o  = 1'b1;
                nibble_c_o = NIB_W'(i);
            end
        end
    end

endmodule

// File: rtl/sevseg_capture.sv
// Receive-side monitor for a multiplexed seven-segment display: synchronises the
// scanned pins, waits for a stable sample and rebuilds one decoded value per digit.
module sevseg_capture
    import sevseg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter int unsigned STABLE_CYCLES  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEG_W-1:0]          seg_pins,
    input  logic [DIGITS-1:0]         sel_pins,
    output logic [NIB_W*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]         digit_valid,
    output logic [SEG_W*DIGITS-1:0]   raw_segs,
    output logic                      update,
    output logic                      frame_done,
    output logic                      overlap_err
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [SEG_W-1:0] SEG_IDLE = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{SEL_ACTIVE_LOW}};

    logic [SEG_W-1:0]  seg_s1_q, seg_s2_q, seg_p_q;
    logic [DIGITS-1:0] sel_s1_q, sel_s2_q, sel_p_q;
    logic [CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
    state_e            state_q;
    logic [SEG_W-1:0]  last_seg_q;
    logic [DIGITS-1:0] last_sel_q;
    logic [DIGITS-1:0] seen_q;
    logic              update_q, frame_q, overlap_q;

    logic [SEG_W-1:0]  seg_n_c;
    logic [DIGITS-1:0] sel_n_c;
    logic [DIGITS-1:0] seen_nx_c;
    logic              sample_chg_c, sel_onehot_c, sel_multi_c, stable_c;
    logic              repeat_c, capture_c, frame_c;
    logic              dec_valid_c;
    logic [NIB_W-1:0]  dec_nib_c;

    // Two-flop synchroniser (reset to the inactive pin levels) plus previous-sample register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= SEG_IDLE;
            seg_s2_q <= SEG_IDLE;
            seg_p_q  <= SEG_IDLE;
            sel_s1_q <= SEL_IDLE;
            sel_s2_q <= SEL_IDLE;
            sel_p_q  <= SEL_IDLE;
        end else begin
            seg_s1_q <= seg_pins;
            seg_s2_q <= seg_s1_q;
            seg_p_q  <= seg_s2_q;
            sel_s1_q <= sel_pins;
            sel_s2_q <= sel_s1_q;
            sel_p_q  <= sel_s2_q;
        end
    end

    always_comb begin
        seg_n_c      = seg_s2_q ^ SEG_IDLE;
        sel_n_c      = sel_s2_q ^ SEL_IDLE;
        sample_chg_c = (seg_s2_q != seg_p_q) || (sel_s2_q != sel_p_q);
        sel_onehot_c = is_onehot(32'(sel_n_c));
        sel_multi_c  = (sel_n_c != '0) && !sel_onehot_c;
        stable_c     = !sample_chg_c && (stab_cnt_q == CNT_MAX);

        if (sample_chg_c) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == CNT_MAX) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end

        // A sample that merely returns to the last captured value (short glitch) is not re-captured.
        repeat_c  = (seg_n_c == last_seg_q) && (sel_n_c == last_sel_q);
        capture_c = (state_q == SETTLE) && stable_c && sel_onehot_c && !repeat_c;
        seen_nx_c = seen_q | sel_n_c;
        frame_c   = &seen_nx_c;
    end

    sevseg_decode u_decode (
        .pattern_i  (seg_n_c),
        .valid_c_o  (dec_valid_c),
        .nibble_c_o (dec_nib_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt_q <= '0;
            state_q    <= IDLE;
            last_seg_q <= '0;
            last_sel_q <= '0;
            seen_q     <= '0;
            update_q   <= 1'b0;
            frame_q    <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            stab_cnt_q <= stab_cnt_d;
            update_q   <= capture_c;
            frame_q    <= capture_c && frame_c;

            case (state_q)
                IDLE: begin
                    last_seg_q <= '0;
                    last_sel_q <= '0;
                    if (sel_onehot_c) begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!sel_onehot_c) begin
                        state_q <= IDLE;
                    end else if (stable_c) begin
                        state_q    <= HELD;
                        last_seg_q <= seg_n_c;
                        last_sel_q <= sel_n_c;
                    end
                end
                HELD: begin
                    if (sample_chg_c) begin
                        state_q <= sel_onehot_c ? SETTLE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The capture completing a frame is kept as the first digit of the next one.
            if (capture_c) begin
                seen_q <= frame_c ? sel_n_c : seen_nx_c;
            end

            if (sel_multi_c && stable_c) begin
                overlap_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        logic [NIB_W-1:0] nib_q;
        logic             vld_q;
        logic [SEG_W-1:0] raw_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                nib_q <= '0;
                vld_q <= 1'b0;
                raw_q <= '0;
            end else if (capture_c && sel_n_c[g]) begin
                nib_q <= dec_valid_c ? dec_nib_c : '0;
                vld_q <= dec_valid_c;
                raw_q <= seg_n_c;
            end
        end

        assign digits[NIB_W*g +: NIB_W]   = nib_q;
        assign digit_valid[g]             = vld_q;
        assign raw_segs[SEG_W*g +: SEG_W] = raw_q;
    end

    assign update      = update_q;
    assign frame_done  = frame_q;
    assign overlap_err = overlap_q;

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture with a queue-based scoreboard on update pulses.
module tb_sevseg_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg_pins = 7'h7F;
    logic [3:0]  sel_pins = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [27:0] raw_segs;
    logic        update, frame_done, overlap_err;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dv;
        logic [27:0] raw;
        logic        fd;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_dig;
    logic [3:0]  m_dv;
    logic [27:0] m_raw;
    int          checks = 0;
    int          errors = 0;
    int          upd_cnt = 0;
    int          fd_cnt = 0;

    sevseg_capture #(
        .DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .STABLE_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_pins    (seg_pins),
        .sel_pins    (sel_pins),
        .digits      (digits),
        .digit_valid (digit_valid),
        .raw_segs    (raw_segs),
        .update      (update),
        .frame_done  (frame_done),
        .overlap_err (overlap_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Update the digit model and queue the full output snapshot expected at that capture.
    task automatic push_exp(input int idx, input logic [6:0] pat, input logic [3:0] nib,
                            input logic v, input logic fd);
        m_dig[idx*4 +: 4] = nib;
        m_dv[idx]         = v;
        m_raw[idx*7 +: 7] = pat;
        exp_q.push_back('{dig: m_dig, dv: m_dv, raw: m_raw, fd: fd});
    endtask

    // Drive an active-low select and an active-high pattern (inverted onto the pins) for n cycles.
    task automatic show(input logic [3:0] sel_al, input logic [6:0] seg_ah, input int n);
        @(negedge clk);
        sel_pins = sel_al;
        seg_pins = ~seg_ah;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sel_pins = 4'hF;
        seg_pins = 7'h7F;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_dig = '0;
        m_dv  = '0;
        m_raw = '0;
        exp_q.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_digits"}, 64'(digits), 64'd0);
        chk({name, "_valid"}, 64'(digit_valid), 64'd0);
        chk({name, "_raw"}, 64'(raw_segs), 64'd0);
        chk({name, "_pulses"}, 64'({update, frame_done}), 64'd0);
        chk({name, "_overlap"}, 64'(overlap_err), 64'd0);
    endtask

    // Monitor: every update pulse must match the next queued snapshot.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done && !update) begin
                chk("frame_without_update", 64'(frame_done), 64'd0);
            end
            if (update) begin
                exp_t e;
                upd_cnt++;
                if (frame_done) fd_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_update", 64'(update), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_digits", 64'(digits), 64'(e.dig));
                    chk("sb_valid", 64'(digit_valid), 64'(e.dv));
                    chk("sb_raw", 64'(raw_segs), 64'(e.raw));
                    chk("sb_frame_done", 64'(frame_done), 64'(e.fd));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, f0;
        m_dig = '0;
        m_dv  = '0;
        m_raw = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_init");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single digit 0 showing "1"
        u0 = upd_cnt;
        push_exp(0, 7'h06, 4'h1, 1'b1, 1'b0);
        show(4'b1110, 7'h06, 30);
        chk("t2_updates", 64'(upd_cnt - u0), 64'd1);
        chk("t2_digit0", 64'(digits[3:0]), 64'h1);
        chk("t2_valid", 64'(digit_valid), 64'h1);
        chk("t2_queue", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a settle window
        u0 = upd_cnt;
        show(4'b1101, 7'h5B, 8);
        #3 rst = 1'b1;
        #1 chk_all_zero("t1_async");
        sel_pins = 4'hF;
        seg_pins = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_dig = '0;
        m_dv  = '0;
        m_raw = '0;
        repeat (40) @(negedge clk);
        chk_all_zero("t1_release");
        chk("t1_no_pulses", 64'(upd_cnt - u0), 64'd0);

        // Full scan of 1,2,3,4
        do_reset();
        u0 = upd_cnt;
        f0 = fd_cnt;
        push_exp(0, 7'h06, 4'h1, 1'b1, 1'b0);
        show(4'b1110, 7'h06, 32);
        push_exp(1, 7'h5B, 4'h2, 1'b1, 1'b0);
        show(4'b1101, 7'h5B, 32);
        push_exp(2, 7'h4F, 4'h3, 1'b1, 1'b0);
        show(4'b1011, 7'h4F, 32);
        push_exp(3, 7'h66, 4'h4, 1'b1, 1'b1);
        show(4'b0111, 7'h66, 32);
        chk("t3_digits", 64'(digits), 64'h4321);
        chk("t3_valid", 64'(digit_valid), 64'hF);
        chk("t3_updates", 64'(upd_cnt - u0), 64'd4);
        chk("t3_frames", 64'(fd_cnt - f0), 64'd1);
        chk("t3_raw", 64'(raw_segs), 64'({7'h66, 7'h4F, 7'h5B, 7'h06}));

        // Short glitch returning to the old value, then a held change
        u0 = upd_cnt;
        show(4'b0111, 7'h7F, 5);
        show(4'b0111, 7'h66, 30);
        chk("t4_glitch_updates", 64'(upd_cnt - u0), 64'd0);
        chk("t4_glitch_digits", 64'(digits), 64'h4321);
        u0 = upd_cnt;
        push_exp(3, 7'h7F, 4'h8, 1'b1, 1'b0);
        show(4'b0111, 7'h7F, 20);
        chk("t4_hold_updates", 64'(upd_cnt - u0), 64'd1);
        chk("t4_hold_digits", 64'(digits), 64'h8321);

        // Two selects active together
        u0 = upd_cnt;
        show(4'b1100, 7'h06, 30);
        chk("t5_overlap", 64'(overlap_err), 64'd1);
        chk("t5_updates", 64'(upd_cnt - u0), 64'd0);
        chk("t5_digits", 64'(digits), 64'h8321);
        push_exp(0, 7'h5B, 4'h2, 1'b1, 1'b0);
        show(4'b1110, 7'h5B, 32);
        chk("t5_sticky", 64'(overlap_err), 64'd1);
        chk("t5_after_digits", 64'(digits), 64'h8322);
        chk("t5_after_updates", 64'(upd_cnt - u0), 64'd1);

        // Unrecognised, blank and letter glyphs
        do_reset();
        chk("t6_overlap_cleared", 64'(overlap_err), 64'd0);
        u0 = upd_cnt;
        push_exp(2, 7'h49, 4'h0, 1'b0, 1'b0);
        show(4'b1011, 7'h49, 32);
        chk("t6_valid2", 64'(digit_valid[2]), 64'd0);
        chk("t6_raw2", 64'(raw_segs[20:14]), 64'h49);
        chk("t6_digit2", 64'(digits[11:8]), 64'h0);
        chk("t6_updates", 64'(upd_cnt - u0), 64'd1);
        f0 = fd_cnt;
        push_exp(1, 7'h00, 4'h0, 1'b0, 1'b0);
        show(4'b1101, 7'h00, 32);
        chk("t6_blank_raw", 64'(raw_segs[13:7]), 64'h0);
        push_exp(3, 7'h7C, 4'hB, 1'b1, 1'b0);
        show(4'b0111, 7'h7C, 32);
        push_exp(0, 7'h79, 4'hE, 1'b1, 1'b1);
        show(4'b1110, 7'h79, 32);
        chk("t6_digits", 64'(digits), 64'hB00E);
        chk("t6_valid", 64'(digit_valid), 64'h9);
        chk("t6_frames", 64'(fd_cnt - f0), 64'd1);
        chk("t6_updates_total", 64'(upd_cnt - u0), 64'd4);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
